// File: rtl/trig_counter_pkg.sv
// rtl/trig_counter_pkg.sv - shared opcodes and word-extract helper for trig_counter_bank
//
// Purpose: command opcode encoding used by the bank top and each counter
// channel, plus a helper that pulls one readout word out of a wide value.
// Ports: none (package).

package trig_counter_pkg;

  typedef enum logic [2:0] {
    OP_NOP     = 3'd0,
    OP_CLR     = 3'd1,
    OP_UP      = 3'd2,
    OP_DOWN    = 3'd3,
    OP_LOAD    = 3'd4,
    OP_CLRFLAG = 3'd5
  } cmd_op_e;

  // Widest counter the helper can slice. Callers zero-extend into this width.
  localparam int MAX_WIDTH = 256;

  // Returns the value shifted so that word number word_idx sits in the LSBs.
  // The caller keeps the low word_bits bits. A word index past the end yields 0.
  function automatic logic [MAX_WIDTH-1:0] word_shift(
    input logic [MAX_WIDTH-1:0] value,
    input int unsigned          word_idx,
    input int unsigned          word_bits
  );
    return value >> (word_idx * word_bits);
  endfunction

endpackage

// File: rtl/trig_counter_ch.sv
// rtl/trig_counter_ch.sv - one up/down counter channel with wrap/saturate and sticky flags
//
// Purpose: a single counter. A decoded command (hit + op) takes priority over
// the free-run increment; CLRFLAG clears the flags and lets free-run proceed.
// Ports:
//   clk1, reset       clock, synchronous active-high reset
//   hit               a valid command addresses this channel this cycle
//   op                command opcode
//   run_en            free-run increment enable
//   sat_mode          1 = saturate at the boundaries, 0 = wrap
//   load_value        value for LOAD
//   count             current count
//   ovf, udf          sticky overflow / underflow flags

import trig_counter_pkg::*;

module trig_counter_ch #(
  parameter int WIDTH = 32
) (
  input  logic             clk1,
  input  logic             reset,
  input  logic             hit,
  input  cmd_op_e          op,
  input  logic             run_en,
  input  logic             sat_mode,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             ovf,
  output logic             udf
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] nxt_count;
  logic             cmd_hit;
  logic             inc;
  logic             dec;
  logic             carry;
  logic             borrow;
  logic             clr_flags;

  // One extra bit so the carry out of max and the borrow out of 0 are visible.
  assign sum  = {1'b0, count} + (WIDTH+1)'(1);
  assign diff = {1'b0, count} - (WIDTH+1)'(1);

  // CLRFLAG, NOP and undefined opcodes do not own the count, so free-run applies.
  assign cmd_hit   = hit && (op == OP_CLR || op == OP_UP || op == OP_DOWN || op == OP_LOAD);
  assign clr_flags = hit && (op == OP_CLRFLAG);

  always_comb begin
    nxt_count = count;
    inc       = 1'b0;
    dec       = 1'b0;
    if (cmd_hit) begin
      case (op)
        OP_CLR:  nxt_count = '0;
        OP_UP:   inc = 1'b1;
        OP_DOWN: dec = 1'b1;
        OP_LOAD: nxt_count = load_value;
        default: ;
      endcase
    end else begin
      inc = run_en;
    end
    carry  = inc && sum[WIDTH];
    borrow = dec && diff[WIDTH];
    if (inc) nxt_count = (carry && sat_mode) ? count : sum[WIDTH-1:0];
    if (dec) nxt_count = (borrow && sat_mode) ? count : diff[WIDTH-1:0];
  end

  always_ff @(posedge clk1) begin
    if (reset) begin
      count <= '0;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else begin
      count <= nxt_count;
      if (clr_flags) begin
        ovf <= 1'b0;
        udf <= 1'b0;
      end else begin
        ovf <= ovf | carry;
        udf <= udf | borrow;
      end
    end
  end

endmodule

// File: rtl/trig_counter_bank.sv
// rtl/trig_counter_bank.sv - bank of N_CH trigger-driven counters with atomic snapshot readout
//
// Purpose: decodes one command per cycle onto N_CH counter channels, captures
// all counts into shadow registers on snap, and serves shadow words through a
// registered read mux so multi-word counts are never torn.
// Ports:
//   clk1, reset                 clock, synchronous active-high reset
//   cmd_valid/cmd_op/cmd_ch     one-cycle command strobe, opcode, channel
//   load_value                  value for LOAD
//   run_en, sat_mode            per-channel free-run enable and saturate mode
//   snap                        capture all counters into shadows
//   rd_ch, rd_word, rd_data     readout select and registered shadow word
//   flags                       {udf, ovf} per channel, channel 0 in the LSBs
//   snap_count                  snapshots taken (wraps)

import trig_counter_pkg::*;

module trig_counter_bank #(
  parameter  int N_CH  = 4,
  parameter  int WIDTH = 32,
  parameter  int WORD  = 16,
  localparam int CHW   = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int NW    = WIDTH / WORD,
  localparam int NWW   = (NW > 1) ? $clog2(NW) : 1
) (
  input  logic              clk1,
  input  logic              reset,
  input  logic              cmd_valid,
  input  logic [2:0]        cmd_op,
  input  logic [CHW-1:0]    cmd_ch,
  input  logic [WIDTH-1:0]  load_value,
  input  logic [N_CH-1:0]   run_en,
  input  logic [N_CH-1:0]   sat_mode,
  input  logic              snap,
  input  logic [CHW-1:0]    rd_ch,
  input  logic [NWW-1:0]    rd_word,
  output logic [WORD-1:0]   rd_data,
  output logic [2*N_CH-1:0] flags,
  output logic [WORD-1:0]   snap_count
);

  logic [WIDTH-1:0]     count  [N_CH];
  logic [WIDTH-1:0]     shadow [N_CH];
  logic [WIDTH-1:0]     sel_shadow;
  logic [MAX_WIDTH-1:0] sel_shifted;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic hit;
    // cmd_ch values past the last channel match no instance and are dropped.
    assign hit = cmd_valid && (cmd_ch == CHW'(g));

    trig_counter_ch #(.WIDTH(WIDTH)) u_ch (
      .clk1       (clk1),
      .reset      (reset),
      .hit        (hit),
      .op         (cmd_op_e'(cmd_op)),
      .run_en     (run_en[g]),
      .sat_mode   (sat_mode[g]),
      .load_value (load_value),
      .count      (count[g]),
      .ovf        (flags[2*g]),
      .udf        (flags[2*g+1])
    );
  end

  // Shadows take the pre-edge counts, so a same-cycle command is not captured.
  always_ff @(posedge clk1) begin
    if (reset) begin
      for (int i = 0; i < N_CH; i++) shadow[i] <= '0;
      snap_count <= '0;
    end else if (snap) begin
      for (int i = 0; i < N_CH; i++) shadow[i] <= count[i];
      snap_count <= snap_count + WORD'(1);
    end
  end

  // An unmatched rd_ch leaves the mux at 0.
  always_comb begin
    sel_shadow = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (rd_ch == CHW'(i)) sel_shadow = shadow[i];
    end
  end

  assign sel_shifted = word_shift(MAX_WIDTH'(sel_shadow), 32'(rd_word), WORD);

  always_ff @(posedge clk1) begin
    if (reset) rd_data <= '0;
    else       rd_data <= sel_shifted[WORD-1:0];
  end

endmodule

// File: tb/tb_trig_counter_bank.sv
// tb/tb_trig_counter_bank.sv - directed scoreboard bench for trig_counter_bank

import trig_counter_pkg::*;

module tb_trig_counter_bank;

  localparam int N_CH  = 4;
  localparam int WIDTH = 32;
  localparam int WORD  = 16;
  localparam int CHW   = 2;
  localparam int NWW   = 1;

  logic              clk1 = 1'b0;
  logic              reset;
  logic              cmd_valid;
  logic [2:0]        cmd_op;
  logic [CHW-1:0]    cmd_ch;
  logic [WIDTH-1:0]  load_value;
  logic [N_CH-1:0]   run_en;
  logic [N_CH-1:0]   sat_mode;
  logic              snap;
  logic [CHW-1:0]    rd_ch;
  logic [NWW-1:0]    rd_word;
  logic [WORD-1:0]   rd_data;
  logic [2*N_CH-1:0] flags;
  logic [WORD-1:0]   snap_count;

  int errors = 0;
  int checks = 0;
  int exp_snaps = 0;

  logic [WORD-1:0] exp_q [$];
  string           tag_q [$];

  trig_counter_bank #(.N_CH(N_CH), .WIDTH(WIDTH), .WORD(WORD)) dut (
    .clk1       (clk1),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_op     (cmd_op),
    .cmd_ch     (cmd_ch),
    .load_value (load_value),
    .run_en     (run_en),
    .sat_mode   (sat_mode),
    .snap       (snap),
    .rd_ch      (rd_ch),
    .rd_word    (rd_word),
    .rd_data    (rd_data),
    .flags      (flags),
    .snap_count (snap_count)
  );

  always #5 clk1 = ~clk1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive a read select, queue the expected word, pop it when rd_data updates.
  task automatic rd(input int c, input int w, input logic [WORD-1:0] exp, input string tag);
    logic [WORD-1:0] e;
    string t;
    rd_ch   = CHW'(c);
    rd_word = NWW'(w);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    tick();
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty: observed 0 entries expected 1");
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      chk(t, 32'(rd_data), 32'(e));
    end
  endtask

  task automatic cmd(input logic [2:0] op, input int c, input logic [WIDTH-1:0] val);
    cmd_valid  = 1'b1;
    cmd_op     = op;
    cmd_ch     = CHW'(c);
    load_value = val;
    tick();
    cmd_valid  = 1'b0;
    cmd_op     = OP_NOP;
  endtask

  task automatic snap_read(input int c, input logic [WIDTH-1:0] exp, input string tag);
    snap = 1'b1;
    tick();
    snap = 1'b0;
    exp_snaps++;
    rd(c, 0, exp[15:0],  {tag, "_w0"});
    rd(c, 1, exp[31:16], {tag, "_w1"});
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = OP_NOP; cmd_ch = '0; load_value = '0;
    run_en = '0; sat_mode = '0; snap = 1'b0; rd_ch = '0; rd_word = '0;
    tick(); tick();
    reset = 1'b0;
    chk("reset_rd_data", 32'(rd_data), 32'h0);
    chk("reset_flags", 32'(flags), 32'h0);
    chk("reset_snap_count", 32'(snap_count), 32'h0);

    // Free-run ch0 for 10 cycles, then snapshot.
    run_en = 4'b0001;
    repeat (10) tick();
    run_en = '0;
    snap_read(0, 32'd10, "run10_ch0");
    for (int c = 1; c < N_CH; c++) begin
      rd(c, 0, 16'h0, "run10_other_w0");
      rd(c, 1, 16'h0, "run10_other_w1");
    end
    chk("snap_count_1", 32'(snap_count), 32'(exp_snaps));

    // ch2 wrap across max.
    sat_mode = 4'b0000;
    cmd(OP_LOAD, 2, 32'hFFFF_FFFE);
    repeat (3) cmd(OP_UP, 2, '0);
    snap_read(2, 32'h0000_0001, "wrap_up_ch2");
    chk("wrap_ovf_ch2", 32'(flags[4]), 32'h1);
    cmd(OP_CLRFLAG, 2, '0);
    chk("clrflag_ovf_ch2", 32'(flags[4]), 32'h0);

    // ch2 saturate at max.
    sat_mode = 4'b0100;
    cmd(OP_LOAD, 2, 32'hFFFF_FFFE);
    repeat (3) cmd(OP_UP, 2, '0);
    snap_read(2, 32'hFFFF_FFFF, "sat_up_ch2");
    chk("sat_ovf_ch2", 32'(flags[4]), 32'h1);

    // ch1 underflow in wrap mode, then clear the flag only.
    cmd(OP_CLR, 1, '0);
    cmd(OP_DOWN, 1, '0);
    snap_read(1, 32'hFFFF_FFFF, "wrap_down_ch1");
    chk("udf_ch1", 32'(flags[3]), 32'h1);
    cmd(OP_CLRFLAG, 1, '0);
    chk("clrflag_udf_ch1", 32'(flags[3]), 32'h0);
    snap_read(1, 32'hFFFF_FFFF, "clrflag_count_ch1");

    // Command and free-run on ch0 together, with a same-cycle snap.
    run_en     = 4'b0001;
    snap       = 1'b1;
    cmd_valid  = 1'b1;
    cmd_op     = OP_UP;
    cmd_ch     = 2'd0;
    tick();
    cmd_valid = 1'b0; cmd_op = OP_NOP; snap = 1'b0; run_en = '0;
    exp_snaps++;
    rd(0, 0, 16'd10, "same_cycle_snap_pre");
    snap_read(0, 32'd11, "cmd_beats_run_ch0");
    chk("snap_count_mid", 32'(snap_count), 32'(exp_snaps));

    // ch3 loaded while free-running; readout must stay coherent while it runs.
    run_en = 4'b1000;
    cmd(OP_LOAD, 3, 32'h0001_FFFF);
    snap = 1'b1;
    tick();
    snap = 1'b0;
    exp_snaps++;
    rd(3, 1, 16'h0001, "notear_w1");
    rd(3, 0, 16'hFFFF, "notear_w0");
    repeat (96) tick();
    rd(3, 1, 16'h0001, "notear_late_w1");
    rd(3, 0, 16'hFFFF, "notear_late_w0");
    chk("snap_count_3", 32'(snap_count), 32'(exp_snaps));

    // Reset mid-run with a command and snap in the same cycle.
    run_en     = 4'b1111;
    rd_ch      = 2'd3;
    rd_word    = 1'b0;
    reset      = 1'b1;
    snap       = 1'b1;
    cmd_valid  = 1'b1;
    cmd_op     = OP_UP;
    cmd_ch     = 2'd0;
    tick();
    reset = 1'b0; snap = 1'b0; cmd_valid = 1'b0; cmd_op = OP_NOP; run_en = '0;
    exp_snaps = 0;
    chk("midreset_rd_data", 32'(rd_data), 32'h0);
    chk("midreset_flags", 32'(flags), 32'h0);
    chk("midreset_snap_count", 32'(snap_count), 32'h0);
    for (int c = 0; c < N_CH; c++) snap_read(c, 32'h0, "midreset_count");
    chk("midreset_snap_count_after", 32'(snap_count), 32'(exp_snaps));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
